// File: rtl/rmt_tx_encap.sv
// rmt_tx_encap: prepends a one-beat Ethernet/IPv4/RMT header to each
// function-engine result frame and truncates frames over the length cap.
module rmt_tx_encap #(
  parameter int DATA_WIDTH        = 512,
  parameter int KEEP_WIDTH        = DATA_WIDTH/8,
  parameter int USER_WIDTH        = 1,
  parameter int DEST_WIDTH        = 2,
  parameter int MAX_PAYLOAD_BEATS = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [47:0]           cfg_dst_mac,
  input  logic [47:0]           cfg_src_mac,
  input  logic [223:0]          cfg_hdr,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [31:0]           stat_frames,
  output logic [15:0]           stat_trunc
);

  localparam int CW = $clog2(MAX_PAYLOAD_BEATS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_PAYLOAD_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    DROP
  } state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [DEST_WIDTH-1:0]   dest_q;
  logic [USER_WIDTH-1:0]   user_q;
  logic                    slot_free;
  logic                    s_fire;
  logic                    trunc;
  logic [DATA_WIDTH-1:0]   hdr;

  assign slot_free = !m_axis_tvalid || m_axis_tready;
  assign s_fire    = s_axis_tvalid && s_axis_tready;
  assign trunc     = !s_axis_tlast && (cnt == LAST_CNT);

  always_comb begin
    s_axis_tready = 1'b0;
    case (state)
      PAYLOAD: s_axis_tready = slot_free;
      DROP:    s_axis_tready = 1'b1;
      default: s_axis_tready = 1'b0;
    endcase
  end

  always_comb begin
    hdr          = '0;
    hdr[0+:48]   = cfg_dst_mac;
    hdr[48+:48]  = cfg_src_mac;
    hdr[96+:16]  = 16'h0008;
    hdr[112+:224] = cfg_hdr;
    hdr[336+:16] = 16'hF0E1;
    hdr[352+:16] = 16'(dest_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      dest_q        <= '0;
      user_q        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      m_axis_tdest  <= '0;
      stat_frames   <= '0;
      stat_trunc    <= '0;
    end else begin
      if (m_axis_tready) m_axis_tvalid <= 1'b0;
      case (state)
        IDLE: begin
          // first beat stays pending; only its sideband is captured
          if (s_axis_tvalid) begin
            dest_q <= s_axis_tdest;
            user_q <= s_axis_tuser;
            state  <= HEADER;
          end
        end
        HEADER: begin
          if (slot_free) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= hdr;
            m_axis_tkeep  <= '1;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= user_q;
            m_axis_tdest  <= dest_q;
            cnt           <= '0;
            state         <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (s_fire) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tkeep  <= s_axis_tkeep;
            m_axis_tlast  <= s_axis_tlast || trunc;
            m_axis_tuser  <= s_axis_tuser;
            m_axis_tdest  <= dest_q;
            cnt           <= cnt + CW'(1);
            if (s_axis_tlast) begin
              stat_frames <= stat_frames + 32'd1;
              state       <= IDLE;
            end else if (trunc) begin
              stat_frames <= stat_frames + 32'd1;
              if (stat_trunc != 16'hFFFF)
                stat_trunc <= stat_trunc + 16'd1;
              state <= DROP;
            end
          end
        end
        DROP: begin
          if (s_fire && s_axis_tlast) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rmt_tx_encap.sv
// tb_rmt_tx_encap: directed and randomized-backpressure checks of the
// header encapsulation, truncation, stats and reset behaviour.
module tb_rmt_tx_encap;

  localparam int DW   = 512;
  localparam int KW   = 64;
  localparam int UW   = 1;
  localparam int TW   = 2;
  localparam int MAXB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [47:0]   cfg_dst_mac;
  logic [47:0]   cfg_src_mac;
  logic [223:0]  cfg_hdr;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [UW-1:0] s_axis_tuser;
  logic [TW-1:0] s_axis_tdest;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic [UW-1:0] m_axis_tuser;
  logic [TW-1:0] m_axis_tdest;
  logic [31:0]   stat_frames;
  logic [15:0]   stat_trunc;

  rmt_tx_encap #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
    .DEST_WIDTH(TW), .MAX_PAYLOAD_BEATS(MAXB)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_dst_mac(cfg_dst_mac), .cfg_src_mac(cfg_src_mac),
    .cfg_hdr(cfg_hdr),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .s_axis_tdest(s_axis_tdest),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .m_axis_tdest(m_axis_tdest),
    .stat_frames(stat_frames), .stat_trunc(stat_trunc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic [UW-1:0] u;
    logic [TW-1:0] t;
    int            c;
  } beat_t;

  beat_t outq[$];
  beat_t expq[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    exp_frames = 0;
  int    exp_trunc = 0;
  bit    rand_rdy = 1'b0;
  int    st;
  int    st2;
  bit    ok;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (!rst && m_axis_tvalid && m_axis_tready) begin
        b.d = m_axis_tdata; b.k = m_axis_tkeep; b.l = m_axis_tlast;
        b.u = m_axis_tuser; b.t = m_axis_tdest; b.c = cyc;
        outq.push_back(b);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(int f, int i);
    logic [31:0] w;
    w = {f[15:0], i[7:0], 8'hC3};
    return {16{w}};
  endfunction

  function automatic logic [KW-1:0] keep_of(int i, int n);
    return (i == n - 1) ? 64'h0000_0000_00FF_FFFF : '1;
  endfunction

  function automatic logic [DW-1:0] hdr_exp(logic [TW-1:0] dest);
    logic [DW-1:0] r;
    r = '0;
    r[0+:48]    = cfg_dst_mac;
    r[48+:48]   = cfg_src_mac;
    r[96+:8]    = 8'h08;
    r[104+:8]   = 8'h00;
    r[112+:224] = cfg_hdr;
    r[336+:8]   = 8'hE1;
    r[344+:8]   = 8'hF0;
    r[352+:16]  = {14'd0, dest};
    return r;
  endfunction

  task automatic wait_hs(output bit okv);
    int t;
    bit hs;
    t = 0;
    hs = 1'b0;
    while (!hs && t < 500) begin
      @(negedge clk);
      hs = s_axis_tready;
      @(posedge clk);
      #1;
      t++;
    end
    okv = hs;
  endtask

  task automatic send_frame(logic [TW-1:0] dest, logic [UW-1:0] user,
                            int n, int f, output int start);
    beat_t b;
    bit    okv;
    b.c = 0;
    b.d = hdr_exp(dest); b.k = '1; b.l = 1'b0; b.u = user; b.t = dest;
    expq.push_back(b);
    for (int i = 0; i < n && i < MAXB; i++) begin
      b.d = pat(f, i);
      b.k = keep_of(i, n);
      b.l = (i == n - 1) || (i == MAXB - 1);
      b.u = user ^ UW'(i == 1);
      b.t = dest;
      expq.push_back(b);
    end
    exp_frames++;
    if (n > MAXB) exp_trunc++;
    start = cyc;
    for (int i = 0; i < n; i++) begin
      s_axis_tdata  = pat(f, i);
      s_axis_tkeep  = keep_of(i, n);
      s_axis_tlast  = (i == n - 1);
      s_axis_tuser  = user ^ UW'(i == 1);
      s_axis_tdest  = (i == 0) ? dest : ~dest;
      s_axis_tvalid = 1'b1;
      wait_hs(okv);
      chk("hs_timeout", DW'(okv), DW'(1));
      if (!okv) break;
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain(string tag);
    int t;
    t = 0;
    while (outq.size() < expq.size() && t < 4000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_count"}, DW'(outq.size()), DW'(expq.size()));
    for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
      chk($sformatf("%s_d%0d", tag, i), outq[i].d, expq[i].d);
      chk($sformatf("%s_k%0d", tag, i), DW'(outq[i].k), DW'(expq[i].k));
      chk($sformatf("%s_l%0d", tag, i), DW'(outq[i].l), DW'(expq[i].l));
      chk($sformatf("%s_u%0d", tag, i), DW'(outq[i].u), DW'(expq[i].u));
      chk($sformatf("%s_t%0d", tag, i), DW'(outq[i].t), DW'(expq[i].t));
    end
    chk({tag, "_frames"}, DW'(stat_frames), DW'(exp_frames));
    chk({tag, "_trunc"}, DW'(stat_trunc), DW'(exp_trunc));
  endtask

  task automatic clear_q();
    outq.delete();
    expq.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cfg_dst_mac   = 48'h6655_4433_2211;
    cfg_src_mac   = 48'hCCBB_AA99_8877;
    cfg_hdr       = {7{32'h1122_3344}};
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = '0;
    s_axis_tdest  = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mvalid", DW'(m_axis_tvalid), DW'(0));
    chk("rst_mdata", m_axis_tdata, '0);
    chk("rst_mkeep", DW'(m_axis_tkeep), DW'(0));
    chk("rst_mside", DW'({m_axis_tlast, m_axis_tuser, m_axis_tdest}), DW'(0));
    chk("rst_sready", DW'(s_axis_tready), DW'(0));
    chk("rst_stats", DW'({stat_frames, stat_trunc}), DW'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // single 3-beat frame, tdest 1
    send_frame(2'd1, 1'b0, 3, 1, st);
    drain("t1");
    chk("t1_dmac", DW'(outq[0].d[0+:48]), DW'(48'h6655_4433_2211));
    chk("t1_etype", DW'(outq[0].d[96+:16]), DW'(16'h0008));
    chk("t1_delim", DW'(outq[0].d[336+:16]), DW'(16'hF0E1));
    chk("t1_func", DW'(outq[0].d[352+:16]), DW'(16'h0001));
    chk("t1_hkeep", DW'(outq[0].k), DW'(64'hFFFF_FFFF_FFFF_FFFF));
    chk("t1_last2", DW'(outq[2].l), DW'(0));
    chk("t1_last3", DW'(outq[3].l), DW'(1));
    chk("t1_keep3", DW'(outq[3].k), DW'(64'h0000_0000_00FF_FFFF));
    chk("t1_frames", DW'(stat_frames), DW'(1));
    chk("t1_lat_hdr", DW'(outq[0].c - st), DW'(2));
    chk("t1_lat_pay", DW'(outq[1].c - st), DW'(3));
    clear_q();

    // single-beat payload, tdest 0
    send_frame(2'd0, 1'b1, 1, 2, st);
    @(negedge clk);
    chk("t2_idle_sready", DW'(s_axis_tready), DW'(0));
    drain("t2");
    chk("t2_func", DW'(outq[0].d[352+:16]), DW'(16'h0000));
    chk("t2_last", DW'(outq[1].l), DW'(1));
    chk("t2_lat_pay", DW'(outq[1].c - st), DW'(3));
    clear_q();

    // truncation: 7 beats in, 4 kept
    send_frame(2'd3, 1'b0, 7, 3, st);
    chk("t3_drop_rate", DW'(cyc - st), DW'(9));
    drain("t3");
    chk("t3_forced_last", DW'(outq[4].l), DW'(1));
    chk("t3_trunc", DW'(stat_trunc), DW'(1));
    clear_q();

    // exactly MAX beats with tlast: not truncated
    send_frame(2'd2, 1'b1, 4, 4, st);
    drain("t3b");
    chk("t3b_trunc", DW'(stat_trunc), DW'(1));
    clear_q();

    // back-to-back frames, dst mac changes during the first
    fork
      begin
        send_frame(2'd1, 1'b0, 4, 10, st);
        send_frame(2'd2, 1'b1, 3, 11, st2);
      end
      begin
        repeat (4) @(posedge clk);
        #1 cfg_dst_mac = 48'hA0A1_A2A3_A4A5;
      end
    join
    chk("t4_b2b", DW'(st2 - st), DW'(6));
    drain("t4");
    chk("t4_mac_old", DW'(outq[0].d[0+:48]), DW'(48'h6655_4433_2211));
    chk("t4_mac_new", DW'(outq[5].d[0+:48]), DW'(48'hA0A1_A2A3_A4A5));
    chk("t4_func1", DW'(outq[0].d[352+:16]), DW'(16'h0001));
    chk("t4_func2", DW'(outq[5].d[352+:16]), DW'(16'h0002));
    clear_q();

    // random backpressure over 100 frames
    rand_rdy = 1'b1;
    for (int f = 0; f < 100; f++)
      send_frame(TW'($urandom_range(0, 3)), UW'($urandom_range(0, 1)),
                 int'($urandom_range(1, 6)), 100 + f, st);
    drain("t5");
    rand_rdy = 1'b0;
    clear_q();

    // reset during payload beat 2
    s_axis_tdata  = pat(200, 0);
    s_axis_tkeep  = '1;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = '0;
    s_axis_tdest  = 2'd2;
    s_axis_tvalid = 1'b1;
    wait_hs(ok);
    chk("t6_first_hs", DW'(ok), DW'(1));
    s_axis_tdata = pat(200, 1);
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_mvalid", DW'(m_axis_tvalid), DW'(0));
    chk("t6_sready", DW'(s_axis_tready), DW'(0));
    chk("t6_stats", DW'({stat_frames, stat_trunc}), DW'(0));
    exp_frames = 0;
    exp_trunc = 0;
    clear_q();
    send_frame(2'd1, 1'b1, 2, 201, st);
    drain("t6");
    clear_q();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
